// File: rtl/pipe_reg_if_id_elastic.sv
// Elastic IF/ID pipeline register: main reg M drives decode, skid reg S absorbs one
// entry under backpressure so in_ready can come straight from a flop.
module pipe_reg_if_id_elastic #(
  parameter int                 PC_W        = 32,
  parameter int                 INSTR_W     = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = '0,
  parameter int                 STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc_plus4,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc_plus4,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam entry_t BUBBLE = '{pc: '0, instr: NOP_INSTR};

  entry_t                 m_q, s_q, in_e;
  logic                   m_valid, s_valid;
  logic                   acc, drn;
  logic [STALL_CNT_W-1:0] stall_q;

  assign in_e = '{pc: in_pc_plus4, instr: in_instr};

  // Ready depends only on the skid flop, never on out_ready.
  assign in_ready = !s_valid;
  assign acc      = in_valid && in_ready;
  assign drn      = m_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= BUBBLE;
      s_q     <= BUBBLE;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= BUBBLE;
    end else if (!m_valid || drn) begin
      // acc implies S empty, so S and input never both need M here.
      if (s_valid) begin
        m_q     <= s_q;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (acc) begin
        m_q     <= in_e;
        m_valid <= 1'b1;
      end else begin
        m_q     <= BUBBLE;
        m_valid <= 1'b0;
      end
    end else if (acc) begin
      s_q     <= in_e;
      s_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (m_valid && !out_ready && !flush && !(&stall_q))
      stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  assign out_valid    = m_valid;
  assign out_pc_plus4 = m_q.pc;
  assign out_instr    = m_q.instr;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipe_reg_if_id_elastic.sv
// Directed bench with a FIFO scoreboard; a second instance with a 4-bit counter
// shares the inputs to exercise stall counter saturation.
module tb_pipe_reg_if_id_elastic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_pc_plus4, in_instr;
  logic        in_ready, out_valid;
  logic [31:0] out_pc_plus4, out_instr;
  logic [15:0] stall_cnt;
  logic        in_ready4, out_valid4;
  logic [31:0] out_pc_plus4_4, out_instr_4;
  logic [3:0]  stall_cnt4;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  logic [15:0] exp_stall;
  logic [3:0]  exp_stall4;
  int          ncmp = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  pipe_reg_if_id_elastic dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_plus4(in_pc_plus4), .in_instr(in_instr), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
    .stall_cnt(stall_cnt)
  );

  pipe_reg_if_id_elastic #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_pc_plus4(in_pc_plus4), .in_instr(in_instr), .out_valid(out_valid4),
    .out_ready(out_ready), .out_pc_plus4(out_pc_plus4_4), .out_instr(out_instr_4),
    .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc_plus4, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_stall_cnt4", {28'd0, stall_cnt4}, 32'd0);
  endtask

  // Asynchronous reset asserted between edges; models discard everything in flight.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1 chk_reset();
    q.delete();
    exp_stall = '0; exp_stall4 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive just after negedge, model the edge, check at next negedge.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                      input bit ordy, input bit fl);
    bit acc_m, drn_m;
    in_valid = v; in_pc_plus4 = pc; in_instr = ins; out_ready = ordy; flush = fl;
    acc_m = v && (q.size() < 2);
    drn_m = (q.size() > 0) && ordy;
    if (drn_m && !fl) begin
      chk("out_pc", out_pc_plus4, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
    end
    if (q.size() > 0 && !ordy && !fl) begin
      if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (exp_stall4 != 4'hF) exp_stall4 = exp_stall4 + 4'd1;
    end
    if (fl) q.delete();
    else begin
      if (drn_m) void'(q.pop_front());
      if (acc_m) q.push_back('{pc: pc, instr: ins});
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_valid4", {31'd0, out_valid4}, {31'd0, q.size() > 0});
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
    chk("stall_cnt4", {28'd0, stall_cnt4}, {28'd0, exp_stall4});
    if (q.size() == 0) begin
      chk("bubble_instr", out_instr, 32'd0);
      chk("bubble_pc", out_pc_plus4, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc_plus4 = '0; in_instr = '0;
    exp_stall = '0; exp_stall4 = '0;
    #12 chk_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, back-to-back
    step(1, 32'd4,  32'h20080001, 1, 0);
    chk("stream_lat_pc", out_pc_plus4, 32'd4);
    step(1, 32'd8,  32'h20090002, 1, 0);
    chk("stream_lat_pc2", out_pc_plus4, 32'd8);
    step(1, 32'd12, 32'h200A0003, 1, 0);
    step(0, 32'd0,  32'd0,        1, 0);
    step(0, 32'd0,  32'd0,        1, 0);

    // Reset mid-transfer with both entries full
    step(1, 32'h100, 32'hAAAA0001, 0, 0);
    step(1, 32'h104, 32'hAAAA0002, 0, 0);
    do_reset();

    // Backpressure: M=4, pc 8 lands in S, pc 12 held off by fetch
    step(1, 32'd4,  32'h20080001, 1, 0);
    step(1, 32'd8,  32'h20090002, 0, 0);
    step(1, 32'd12, 32'h200A0003, 0, 0);
    chk("bp_m_stable", out_pc_plus4, 32'd4);
    step(1, 32'd12, 32'h200A0003, 0, 0);
    chk("bp_stall3", {16'd0, stall_cnt}, 32'd3);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    step(1, 32'd12, 32'h200A0003, 1, 0);
    step(1, 32'd12, 32'h200A0003, 1, 0);
    step(0, 32'd0,  32'd0,        1, 0);
    step(0, 32'd0,  32'd0,        1, 0);

    // Flush with both entries valid and a fresh input offered
    step(1, 32'h200, 32'h11110001, 0, 0);
    step(1, 32'h204, 32'h11110002, 0, 0);
    step(1, 32'h208, 32'h11110003, 0, 1);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_nop", out_instr, 32'd0);
    step(1, 32'h300, 32'h22220001, 1, 0);
    step(0, 32'd0,   32'd0,        1, 0);

    // Saturation on the 4-bit counter
    step(1, 32'h400, 32'h33330001, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 32'd0, 32'd0, 0, 0);
    chk("sat_stall4", {28'd0, stall_cnt4}, 32'd15);
    step(0, 32'd0, 32'd0, 1, 0);

    // Simultaneous: S drains into M while a new input is refused, then taken
    step(1, 32'h500, 32'h44440001, 0, 0);
    step(1, 32'h504, 32'h44440002, 0, 0);
    step(1, 32'h508, 32'h44440003, 1, 0);
    chk("simul_m_from_s", out_pc_plus4, 32'h504);
    step(1, 32'h508, 32'h44440003, 1, 0);
    chk("simul_taken", out_pc_plus4, 32'h508);
    step(0, 32'd0,   32'd0,        1, 0);
    step(0, 32'd0,   32'd0,        1, 0);

    chk("sb_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
